// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared definitions for the fetch PC redirect controller: op codes, FSM states
// and the default reset PC.
package pc_redirect_ctrl_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    localparam logic [2:0] NPC_NORMAL = 3'b000;
    localparam logic [2:0] NPC_JIMM   = 3'b001;
    localparam logic [2:0] NPC_JINDEX = 3'b010;
    localparam logic [2:0] NPC_JREG   = 3'b011;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_e;

endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// Redirect request channel from decode-stage branch resolution to the PC controller.
interface pc_redirect_ctrl_if;

    logic        redir_valid;
    logic        redir_ready;
    logic [2:0]  redir_op;
    logic        redir_taken;
    logic [31:0] redir_bpc;
    logic [31:0] redir_imm;
    logic [31:0] redir_reg;

    modport master (
        output redir_valid, redir_op, redir_taken, redir_bpc, redir_imm, redir_reg,
        input  redir_ready
    );

    modport slave (
        input  redir_valid, redir_op, redir_taken, redir_bpc, redir_imm, redir_reg,
        output redir_ready
    );

endinterface

// File: rtl/pc_redirect_ctrl_npc_target_calc.sv
// Combinational next-PC target and effective-redirect decode.
// With PC_ALIGN_CHECK_EN defined, targets are word-aligned and misalignment is flagged.
module npc_target_calc
    import pc_redirect_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic [2:0]  op,
    input  logic        taken,
    input  logic [31:0] bpc,
    input  logic [31:0] imm,
    input  logic [31:0] reg_tgt,
    output logic        redirect,
    output logic [31:0] target,
    output logic        align_fault
);

    logic [31:0] raw_target;

    // Not-taken branches and op 000 are not redirects at all.
    always_comb begin
        redirect   = 1'b0;
        raw_target = '0;
        if (op[2]) begin
            redirect   = 1'b1;
            raw_target = RESET_PC;
        end else begin
            case (op)
                NPC_JIMM: begin
                    if (taken) begin
                        redirect   = 1'b1;
                        raw_target = bpc + 32'd4 + (imm << 2);
                    end
                end
                NPC_JINDEX: begin
                    redirect   = 1'b1;
                    raw_target = {bpc[31:28], imm[25:0], 2'b00};
                end
                NPC_JREG: begin
                    redirect   = 1'b1;
                    raw_target = reg_tgt;
                end
                default: begin
                    redirect   = 1'b0;
                    raw_target = '0;
                end
            endcase
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    assign target      = {raw_target[31:2], 2'b00};
    assign align_fault = redirect & (|raw_target[1:0]);
`else
    assign target      = raw_target;
    assign align_fault = 1'b0;
`endif

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC register with a single-entry buffer for redirects that arrive during a stall.
// Optional sticky alignment flag under PC_ALIGN_CHECK_EN.
module pc_redirect_ctrl
    import pc_redirect_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          ADDR_W   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall_i,
    pc_redirect_ctrl_if.slave    rif,
    output logic [ADDR_W-1:0]    pc_o,
    output logic                 pend_o,
    output logic                 align_err_o
);

    state_e      state, state_nxt;
    logic [31:0] pc_q, pc_nxt;
    logic [31:0] pend_q, pend_nxt;
    logic        err_q, err_nxt;
    logic        redirect;
    logic [31:0] target;
    logic        align_fault;
    logic        accept;

    npc_target_calc #(
        .RESET_PC (RESET_PC)
    ) u_target (
        .op          (rif.redir_op),
        .taken       (rif.redir_taken),
        .bpc         (rif.redir_bpc),
        .imm         (rif.redir_imm),
        .reg_tgt     (rif.redir_reg),
        .redirect    (redirect),
        .target      (target),
        .align_fault (align_fault)
    );

    assign rif.redir_ready = (state == ST_RUN);
    assign accept          = rif.redir_valid & rif.redir_ready & redirect;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_RUN;
            pc_q   <= RESET_PC;
            pend_q <= '0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            pc_q   <= pc_nxt;
            pend_q <= pend_nxt;
            err_q  <= err_nxt;
        end
    end

    // Leaving PEND always applies the buffered target; a new request waits for RUN.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        pend_nxt  = pend_q;
        err_nxt   = err_q | (accept & align_fault);
        case (state)
            ST_RUN: begin
                if (accept) begin
                    if (stall_i) begin
                        pend_nxt  = target;
                        state_nxt = ST_PEND;
                    end else begin
                        pc_nxt = target;
                    end
                end else if (!stall_i) begin
                    pc_nxt = pc_q + 32'd4;
                end
            end
            ST_PEND: begin
                if (!stall_i) begin
                    pc_nxt    = pend_q;
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    assign pc_o        = pc_q;
    assign pend_o      = (state == ST_PEND);
    assign align_err_o = err_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed self-checking bench for pc_redirect_ctrl (alignment checks follow PC_ALIGN_CHECK_EN).
module tb_pc_redirect_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [31:0] pc;
    logic        pend;
    logic        err;
    int          passCount = 0;
    int          checkCount = 0;

    pc_redirect_ctrl_if rif ();

    pc_redirect_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .stall_i     (stall),
        .rif         (rif),
        .pc_o        (pc),
        .pend_o      (pend),
        .align_err_o (err)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic st, input logic vld, input logic [2:0] op,
                                 input logic tk, input logic [31:0] bpc,
                                 input logic [31:0] imm, input logic [31:0] rg);
        stall           = st;
        rif.redir_valid = vld;
        rif.redir_op    = op;
        rif.redir_taken = tk;
        rif.redir_bpc   = bpc;
        rif.redir_imm   = imm;
        rif.redir_reg   = rg;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        applyStimulus(0, 0, 3'b000, 0, 32'h0, 32'h0, 32'h0);
        reset = 1'b1;
        #2;
        checkOutput("reset_pc", pc, 32'h0000_3000);
        checkOutput("reset_pend", {31'b0, pend}, 32'd0);
        checkOutput("reset_ready", {31'b0, rif.redir_ready}, 32'd1);
        checkOutput("reset_err", {31'b0, err}, 32'd0);
        #5 reset = 1'b0;

        step(); checkOutput("seq_3004", pc, 32'h0000_3004);
        step(); checkOutput("seq_3008", pc, 32'h0000_3008);
        step(); checkOutput("seq_300c", pc, 32'h0000_300C);

        #2 reset = 1'b1;
        #1 checkOutput("async_reset_pc", pc, 32'h0000_3000);
        #1 reset = 1'b0;
        step(); step(); step(); step();
        checkOutput("seq_3010", pc, 32'h0000_3010);

        applyStimulus(0, 1, 3'b001, 1, 32'h0000_300C, 32'hFFFF_FFFD, 32'h0);
        step(); checkOutput("branch_taken_back", pc, 32'h0000_3004);
        applyStimulus(0, 1, 3'b001, 0, 32'h0000_300C, 32'hFFFF_FFFD, 32'h0);
        step(); checkOutput("branch_not_taken", pc, 32'h0000_3008);

        applyStimulus(1, 1, 3'b010, 0, 32'h0000_3020, 32'h0000_0100, 32'h0);
        step();
        checkOutput("stall_buffer_pc", pc, 32'h0000_3008);
        checkOutput("stall_buffer_pend", {31'b0, pend}, 32'd1);
        checkOutput("stall_buffer_ready", {31'b0, rif.redir_ready}, 32'd0);
        applyStimulus(1, 0, 3'b000, 0, 32'h0, 32'h0, 32'h0);
        step(); step();
        checkOutput("pend_hold_pc", pc, 32'h0000_3008);
        checkOutput("pend_hold_pend", {31'b0, pend}, 32'd1);
        applyStimulus(0, 0, 3'b000, 0, 32'h0, 32'h0, 32'h0);
        step();
        checkOutput("pend_release_pc", pc, 32'h0000_0400);
        checkOutput("pend_release_pend", {31'b0, pend}, 32'd0);

        applyStimulus(1, 1, 3'b011, 0, 32'h0, 32'h0, 32'h0000_6000);
        step();
        checkOutput("pend2_pc", pc, 32'h0000_0400);
        checkOutput("pend2_pend", {31'b0, pend}, 32'd1);
        applyStimulus(0, 1, 3'b011, 0, 32'h0, 32'h0, 32'h0000_5000);
        step();
        checkOutput("pend_wins_pc", pc, 32'h0000_6000);
        checkOutput("pend_wins_ready", {31'b0, rif.redir_ready}, 32'd1);
        step();
        checkOutput("next_req_pc", pc, 32'h0000_5000);

        applyStimulus(1, 1, 3'b001, 0, 32'h0000_1000, 32'h0000_0010, 32'h0);
        step();
        checkOutput("nt_stall_pend", {31'b0, pend}, 32'd0);
        checkOutput("nt_stall_pc", pc, 32'h0000_5000);
        applyStimulus(1, 1, 3'b000, 0, 32'h0, 32'h0, 32'h0000_9000);
        step();
        checkOutput("normal_stall_pend", {31'b0, pend}, 32'd0);
        applyStimulus(0, 0, 3'b000, 0, 32'h0, 32'h0, 32'h0);
        step();
        checkOutput("resume_pc", pc, 32'h0000_5004);

        applyStimulus(0, 1, 3'b011, 0, 32'h0, 32'h0, 32'hFFFF_FFFC);
        step(); checkOutput("jreg_top", pc, 32'hFFFF_FFFC);
        applyStimulus(0, 0, 3'b000, 0, 32'h0, 32'h0, 32'h0);
        step(); checkOutput("wrap_zero", pc, 32'h0000_0000);
        applyStimulus(0, 1, 3'b101, 0, 32'h0, 32'h0, 32'h0);
        step(); checkOutput("illegal_op", pc, 32'h0000_3000);
        applyStimulus(0, 1, 3'b001, 1, 32'hFFFF_FFFC, 32'h0000_0001, 32'h0);
        step(); checkOutput("branch_wrap", pc, 32'h0000_0004);

        applyStimulus(0, 1, 3'b011, 0, 32'h0, 32'h0, 32'h0000_4002);
        step();
`ifdef PC_ALIGN_CHECK_EN
        checkOutput("align_pc", pc, 32'h0000_4000);
        checkOutput("align_err", {31'b0, err}, 32'd1);
`else
        checkOutput("align_pc", pc, 32'h0000_4002);
        checkOutput("align_err", {31'b0, err}, 32'd0);
`endif
        applyStimulus(0, 0, 3'b000, 0, 32'h0, 32'h0, 32'h0);
        step();
`ifdef PC_ALIGN_CHECK_EN
        checkOutput("align_err_sticky", {31'b0, err}, 32'd1);
`else
        checkOutput("align_err_sticky", {31'b0, err}, 32'd0);
`endif

        applyStimulus(1, 1, 3'b011, 0, 32'h0, 32'h0, 32'h0000_8000);
        step();
        checkOutput("pre_reset_pend", {31'b0, pend}, 32'd1);
        applyStimulus(1, 0, 3'b000, 0, 32'h0, 32'h0, 32'h0);
        #2 reset = 1'b1;
        #1;
        checkOutput("pend_reset_pend", {31'b0, pend}, 32'd0);
        checkOutput("pend_reset_pc", pc, 32'h0000_3000);
        checkOutput("pend_reset_err", {31'b0, err}, 32'd0);
        #1 reset = 1'b0;
        applyStimulus(0, 0, 3'b000, 0, 32'h0, 32'h0, 32'h0);
        step();
        checkOutput("pend_discarded_pc", pc, 32'h0000_3004);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
